// File: rtl/miner_pkg.sv
// Shared types for the miner dispatch block: FSM states, core-count limit and
// the job descriptor latched on every new_work pulse.
package miner_pkg;

    localparam int MAX_CORE_LOG2 = 3;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SPLIT  = 2'd1,
        S_LAUNCH = 2'd2,
        S_RUN    = 2'd3
    } dispatch_state_e;

    typedef struct packed {
        logic [255:0] midstate;
        logic [95:0]  work_data;
        logic [31:0]  nonce_min;
        logic [31:0]  nonce_max;
    } job_t;

endpackage

// File: rtl/miner_dispatch_if.sv
// Golden-nonce stream from miner_dispatch back to the comm side (valid/ready).
interface miner_dispatch_if;
    import miner_pkg::*;

    logic                     gn_valid;
    logic                     gn_ready;
    logic [31:0]              gn_nonce;
    logic [MAX_CORE_LOG2-1:0] gn_core;

    modport master (output gn_valid, gn_nonce, gn_core, input gn_ready);
    modport slave  (input gn_valid, gn_nonce, gn_core, output gn_ready);
endinterface

// File: rtl/miner_dispatch_gn_fifo.sv
// Synchronous FIFO for golden nonces: push/pop handshake, flush, full/empty.
// DEPTH_LOG2 must be at least 1.
module gn_fifo #(
    parameter int unsigned WIDTH      = 35,
    parameter int unsigned DEPTH_LOG2 = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] out_data,
    output logic             full,
    output logic             empty
);
    logic [WIDTH-1:0]    mem [1 << DEPTH_LOG2];
    logic [DEPTH_LOG2:0] wr_ptr, rd_ptr;
    logic                do_push, do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                     (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign out_data = empty ? '0 : mem[rd_ptr[DEPTH_LOG2-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr[DEPTH_LOG2-1:0]] <= push_data;
    end
endmodule

// File: rtl/miner_dispatch.sv
// Job scheduler: splits a nonce range over 2**CORE_LOG2 cores and funnels golden
// nonces back through a round-robin arbiter and FIFO. Optional: DISPATCH_WATCHDOG_EN.
module miner_dispatch
    import miner_pkg::*;
#(
    parameter int unsigned CORE_LOG2   = 2,
    parameter int unsigned FIFO_LOG2   = 2,
    parameter logic [33:0] WDOG_CYCLES = 34'h3_FFFF_FFFF
) (
    input  logic                           hash_clk,
    input  logic                           reset_n,
    input  logic                           new_work,
    input  logic [255:0]                   midstate,
    input  logic [95:0]                    work_data,
    input  logic [31:0]                    nonce_min,
    input  logic [31:0]                    nonce_max,
    output logic [255:0]                   core_midstate,
    output logic [95:0]                    core_work_data,
    output logic [32*(1 << CORE_LOG2)-1:0] core_nonce_min,
    output logic [32*(1 << CORE_LOG2)-1:0] core_nonce_max,
    output logic [(1 << CORE_LOG2)-1:0]    core_start,
    input  logic [(1 << CORE_LOG2)-1:0]    core_done,
    input  logic [(1 << CORE_LOG2)-1:0]    core_ticket,
    input  logic [32*(1 << CORE_LOG2)-1:0] core_nonce,
    miner_dispatch_if.master               gn,
    output logic                           job_active,
    output logic                           job_done,
    output logic                           range_err,
`ifdef DISPATCH_WATCHDOG_EN
    output logic                           stall,
`endif
    output logic [7:0]                     drop_count
);
    localparam int N  = 1 << CORE_LOG2;
    localparam int IW = MAX_CORE_LOG2;
    localparam logic [IW-1:0] IDX_MASK = IW'(N - 1);

    localparam logic [1:0] ST_IDLE   = S_IDLE;
    localparam logic [1:0] ST_SPLIT  = S_SPLIT;
    localparam logic [1:0] ST_LAUNCH = S_LAUNCH;
    localparam logic [1:0] ST_RUN    = S_RUN;

    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [3:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {5'b0, b};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

    logic [1:0]    state;
    logic [IW-1:0] split_idx;
    logic [31:0]   cursor, cur_min;
    logic [32:0]   chunk, span_w, chunk_w;
    logic          chunk_zero, range_bad, all_done;
    logic [N-1:0]  started;
    job_t          job_q;

    assign range_bad  = nonce_min > nonce_max;
    assign span_w     = {1'b0, nonce_max} - {1'b0, nonce_min} + 33'd1;
    assign chunk_w    = span_w >> CORE_LOG2;
    assign chunk_zero = (chunk == '0);
    assign cur_min    = (split_idx == '0) ? job_q.nonce_min : cursor;
    assign all_done   = &(core_done | ~started);
    assign job_active = (state == ST_LAUNCH) || (state == ST_RUN);
    assign core_midstate  = job_q.midstate;
    assign core_work_data = job_q.work_data;

    always_ff @(posedge hash_clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_IDLE;
            split_idx      <= '0;
            cursor         <= '0;
            chunk          <= '0;
            started        <= '0;
            job_q          <= '0;
            range_err      <= 1'b0;
            core_start     <= '0;
            job_done       <= 1'b0;
            core_nonce_min <= '0;
            core_nonce_max <= '0;
        end else begin
            core_start <= '0;
            job_done   <= 1'b0;
            if (new_work) begin
                if (range_bad) begin
                    range_err <= 1'b1;
                    state     <= ST_IDLE;
                end else begin
                    range_err       <= 1'b0;
                    state           <= ST_SPLIT;
                    job_q.midstate  <= midstate;
                    job_q.work_data <= work_data;
                    job_q.nonce_min <= nonce_min;
                    job_q.nonce_max <= nonce_max;
                    chunk           <= chunk_w;
                    split_idx       <= '0;
                    started         <= (chunk_w == '0) ? N'(1) : '1;
                end
            end else begin
                case (state)
                    // one core per cycle; the last core absorbs the remainder
                    ST_SPLIT: begin
                        for (int i = 0; i < N; i++) begin
                            if (split_idx == IW'(i)) begin
                                if (i == 0 || !chunk_zero) begin
                                    core_nonce_min[32*i +: 32] <= cur_min;
                                    core_nonce_max[32*i +: 32] <= (i == N - 1 || chunk_zero) ?
                                        job_q.nonce_max : cur_min + chunk[31:0] - 32'd1;
                                end else begin
                                    core_nonce_min[32*i +: 32] <= '0;
                                    core_nonce_max[32*i +: 32] <= '0;
                                end
                            end
                        end
                        cursor    <= cur_min + chunk[31:0];
                        split_idx <= split_idx + 1'b1;
                        if (split_idx == IDX_MASK) begin
                            state      <= ST_LAUNCH;
                            core_start <= started;
                        end
                    end
                    ST_LAUNCH: state <= ST_RUN;
                    ST_RUN: begin
                        if (all_done) begin
                            state    <= ST_IDLE;
                            job_done <= 1'b1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    logic [N-1:0]    pending, grant, accept, drop_vec;
    logic [31:0]     pend_nonce [N];
    logic [IW-1:0]   last_idx, grant_idx;
    logic            found, can_push, do_grant, fifo_full, fifo_empty;
    logic [31:0]     push_nonce;
    logic [3:0]      n_drop;
    logic [IW+31:0]  fifo_out;

    // Round-robin search starting one past the previous grant.
    always_comb begin
        found     = 1'b0;
        grant_idx = last_idx;
        for (int k = 1; k <= N; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!found && pending[i] && (IW'(i) == ((last_idx + IW'(k)) & IDX_MASK))) begin
                    found     = 1'b1;
                    grant_idx = IW'(i);
                end
            end
        end
    end

    assign can_push = !fifo_full || gn.gn_ready;
    assign do_grant = found && can_push && !new_work;

    always_comb begin
        grant      = '0;
        push_nonce = '0;
        for (int i = 0; i < N; i++) begin
            if (do_grant && grant_idx == IW'(i)) begin
                grant[i]   = 1'b1;
                push_nonce = pend_nonce[i];
            end
        end
    end

    // A latch being granted this cycle is free again for a simultaneous ticket.
    assign accept   = ~pending | grant;
    assign drop_vec = core_ticket & ~accept;

    always_comb begin
        n_drop = '0;
        for (int i = 0; i < N; i++) n_drop = n_drop + {3'b0, drop_vec[i]};
    end

    always_ff @(posedge hash_clk or negedge reset_n) begin
        if (!reset_n) begin
            pending    <= '0;
            last_idx   <= IDX_MASK;
            drop_count <= '0;
        end else if (new_work) begin
            pending  <= '0;
            last_idx <= IDX_MASK;
        end else begin
            pending    <= (pending & ~grant) | core_ticket;
            drop_count <= sat_add8(drop_count, n_drop);
            if (do_grant) last_idx <= grant_idx;
        end
    end

    always_ff @(posedge hash_clk) begin
        for (int i = 0; i < N; i++) begin
            if (core_ticket[i] && accept[i] && !new_work)
                pend_nonce[i] <= core_nonce[32*i +: 32];
        end
    end

    gn_fifo #(
        .WIDTH      (IW + 32),
        .DEPTH_LOG2 (FIFO_LOG2)
    ) u_gn_fifo (
        .clk       (hash_clk),
        .rst_n     (reset_n),
        .flush     (new_work),
        .push      (do_grant),
        .push_data ({grant_idx, push_nonce}),
        .pop       (gn.gn_ready),
        .out_data  (fifo_out),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign gn.gn_valid = !fifo_empty;
    assign gn.gn_nonce = fifo_out[31:0];
    assign gn.gn_core  = fifo_out[IW+31:32];

`ifdef DISPATCH_WATCHDOG_EN
    logic [33:0]  wdog_cnt;
    logic [N-1:0] done_prev;

    always_ff @(posedge hash_clk or negedge reset_n) begin
        if (!reset_n) begin
            wdog_cnt  <= '0;
            done_prev <= '0;
            stall     <= 1'b0;
        end else begin
            done_prev <= core_done;
            if (new_work) begin
                wdog_cnt <= '0;
                stall    <= 1'b0;
            end else if (state != ST_RUN || core_done != done_prev) begin
                wdog_cnt <= '0;
            end else if (wdog_cnt == WDOG_CYCLES) begin
                stall <= 1'b1;
            end else begin
                wdog_cnt <= wdog_cnt + 34'd1;
            end
        end
    end
`endif
endmodule
